// File: rtl/adder8_feeder.sv
// rtl/adder8_feeder.sv - operand issue and result collection stage for the registered adder8
//
// Buffers operand pairs in an input queue, issues one pair per cycle to adder8
// through registers, follows each op down adder8's pipeline with a shift
// register, and captures adder8's sum into an output FIFO. Issue is
// credit-limited so the output FIFO can never overflow.
//
// Ports:
//   clk                   clock, rising edge
//   rst                   synchronous active-low reset (shared with adder8)
//   in_valid/in_ready     operand pair handshake; in_a, in_b are the operands
//   add_in0/add_in1       registered operands driven into adder8 in0/in1
//   add_out               adder8 result
//   res_valid/res_ready   result handshake; res_data is the result FIFO head
//   busy                  anything queued, in flight or buffered
//
// IN_DEPTH and OUT_DEPTH must be powers of two (pointer wrap is by natural
// overflow); ADDER_LAT >= 1; OUT_DEPTH >= ADDER_LAT+1.

module adder8_feeder #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int ADDER_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic [7:0] add_in0,
  output logic [7:0] add_in1,
  input  logic [7:0] add_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       busy
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  // Wide enough for out count plus every in-flight bit.
  localparam int CW  = $clog2(OUT_DEPTH + ADDER_LAT + 2) + 1;

  logic [IAW:0]       r_in_wr;
  logic [IAW:0]       r_in_rd;
  logic [7:0]         r_in_a_mem [IN_DEPTH];
  logic [7:0]         r_in_b_mem [IN_DEPTH];

  logic [OAW:0]       r_out_wr;
  logic [OAW:0]       r_out_rd;
  logic [7:0]         r_out_mem [OUT_DEPTH];

  // Bit k set: an op was issued k+1 edges ago. The top bit marks the cycle
  // in which add_out holds that op's sum.
  logic [ADDER_LAT:0] r_inflight;

  logic [7:0]         r_add_in0;
  logic [7:0]         r_add_in1;

  logic               w_in_empty;
  logic               w_in_full;
  logic               w_out_empty;
  logic [OAW:0]       w_out_count;
  logic [CW-1:0]      w_used;
  logic               w_issue;
  logic               w_in_push;
  logic               w_out_push;
  logic               w_out_pop;

  assign w_in_empty  = (r_in_wr == r_in_rd);
  assign w_in_full   = ((r_in_wr ^ r_in_rd) == {1'b1, {IAW{1'b0}}});
  assign w_out_empty = (r_out_wr == r_out_rd);
  assign w_out_count = r_out_wr - r_out_rd;

  // Credits in use: results already buffered plus ops still in the adder.
  // Uses the registered out count, so a same-cycle pop frees its credit only
  // from the next cycle on.
  always_comb begin
    w_used = CW'(w_out_count);
    for (int i = 0; i <= ADDER_LAT; i++) begin
      w_used = w_used + CW'(r_inflight[i]);
    end
  end

  assign w_issue    = !w_in_empty && (w_used < CW'(OUT_DEPTH));
  assign in_ready   = rst & ~w_in_full;
  assign w_in_push  = in_valid & in_ready;
  assign w_out_push = r_inflight[ADDER_LAT];
  assign w_out_pop  = res_valid & res_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_in_wr    <= '0;
      r_in_rd    <= '0;
      r_out_wr   <= '0;
      r_out_rd   <= '0;
      r_inflight <= '0;
      r_add_in0  <= 8'h00;
      r_add_in1  <= 8'h00;
    end else begin
      if (w_in_push) begin
        r_in_wr <= r_in_wr + 1'b1;
      end
      if (w_issue) begin
        r_add_in0 <= r_in_a_mem[r_in_rd[IAW-1:0]];
        r_add_in1 <= r_in_b_mem[r_in_rd[IAW-1:0]];
        r_in_rd   <= r_in_rd + 1'b1;
      end
      r_inflight <= {r_inflight[ADDER_LAT-1:0], w_issue};
      if (w_out_push) begin
        r_out_wr <= r_out_wr + 1'b1;
      end
      if (w_out_pop) begin
        r_out_rd <= r_out_rd + 1'b1;
      end
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_in_push) begin
      r_in_a_mem[r_in_wr[IAW-1:0]] <= in_a;
      r_in_b_mem[r_in_wr[IAW-1:0]] <= in_b;
    end
    if (w_out_push) begin
      r_out_mem[r_out_wr[OAW-1:0]] <= add_out;
    end
  end

  assign add_in0   = r_add_in0;
  assign add_in1   = r_add_in1;
  assign res_valid = !w_out_empty;
  // Forced to zero when empty so stale entries never show after reset.
  assign res_data  = w_out_empty ? 8'h00 : r_out_mem[r_out_rd[OAW-1:0]];
  assign busy      = !w_in_empty | (|r_inflight) | !w_out_empty;

endmodule

// File: tb/tb_adder8_feeder.sv
// tb/tb_adder8_feeder.sv - self-checking bench for adder8_feeder with a behavioural adder8

module tb_adder8_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] add_in0;
  logic [7:0] add_in1;
  logic [7:0] add_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       busy;

  always #5 clk = ~clk;

  adder8_feeder #(.IN_DEPTH(4), .OUT_DEPTH(4), .ADDER_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_in0(add_in0), .add_in1(add_in1), .add_out(add_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  // Registered adder8: one clock latency, carry discarded.
  always @(posedge clk) begin
    if (!rst) add_out <= 8'h00;
    else      add_out <= 8'(add_in0 + add_in1);
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         n_acc   = 0;
  int         n_pop   = 0;
  logic [7:0] sb[$];
  logic [7:0] got[$];
  int         pop_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample handshakes mid-cycle, update the scoreboard, then advance one edge.
  task automatic tick();
    logic [7:0] exp;
    #2;
    if (!rst) sb.delete();
    if (res_valid && res_ready) begin
      n_pop++;
      got.push_back(res_data);
      pop_cyc.push_back(cyc);
      n_tests++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed result %0h expected none", res_data);
      end
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check("sb_data", {24'h0, res_data}, {24'h0, exp});
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(8'(in_a + in_b));
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int k;
    k = 0;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    while ((sb.size() != 0 || busy) && k < 40) begin
      tick();
      k++;
    end
    check("drain_timeout", {31'h0, k < 40}, 32'h1);
  endtask

  // Offer fresh pairs for 12 cycles with the result side stalled.
  task automatic fill_stalled();
    res_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_a = 8'(n_acc * 37 + 90);
      in_b = 8'(n_acc * 11 + 200);
      tick();
    end
  endtask

  int acc0;
  int pop0;
  int acc_late;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'h00;
    in_b      = 8'h01;
    res_ready = 1'b0;

    // Reset held two edges with in_valid asserted.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_in_ready",  {31'h0, in_ready},  32'h0);
      check("rst_res_valid", {31'h0, res_valid}, 32'h0);
      check("rst_add_in0",   {24'h0, add_in0},   32'h0);
      check("rst_add_in1",   {24'h0, add_in1},   32'h0);
      check("rst_res_data",  {24'h0, res_data},  32'h0);
      check("rst_busy",      {31'h0, busy},      32'h0);
    end
    check("rst_no_accept", n_acc, 0);

    // Single op (00,01), latency of three edges.
    rst = 1'b1;
    #1;
    check("rel_in_ready", {31'h0, in_ready}, 32'h1);
    tick();
    check("single_acc", n_acc, 1);
    in_valid = 1'b0;
    tick();
    check("single_add_in0", {24'h0, add_in0}, 32'h00);
    check("single_add_in1", {24'h0, add_in1}, 32'h01);
    check("single_e1_valid", {31'h0, res_valid}, 32'h0);
    tick();
    check("single_e2_valid", {31'h0, res_valid}, 32'h0);
    tick();
    check("single_e3_valid", {31'h0, res_valid}, 32'h1);
    check("single_e3_data", {24'h0, res_data}, 32'h01);
    res_ready = 1'b1;
    tick();
    check("single_busy_after", {31'h0, busy}, 32'h0);

    // Back-to-back stream with carry wrap.
    got.delete();
    pop_cyc.delete();
    acc0 = n_acc;
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = 8'h09; in_b = 8'h01; tick();
    in_a = 8'h1C; in_b = 8'h01; tick();
    in_a = 8'hA3; in_b = 8'h01; tick();
    in_a = 8'hFF; in_b = 8'h02; tick();
    check("stream_acc", n_acc - acc0, 4);
    drain();
    check("stream_count", got.size(), 4);
    check("stream_r0", {24'h0, got[0]}, 32'h0A);
    check("stream_r1", {24'h0, got[1]}, 32'h1D);
    check("stream_r2", {24'h0, got[2]}, 32'hA4);
    check("stream_r3", {24'h0, got[3]}, 32'h01);
    check("stream_rate", pop_cyc[3] - pop_cyc[0], 3);

    // Backpressure: 8 accepted, then in_ready low; drain in order.
    got.delete();
    acc0 = n_acc;
    fill_stalled();
    check("bp_acc", n_acc - acc0, 8);
    check("bp_in_ready", {31'h0, in_ready}, 32'h0);
    check("bp_res_valid", {31'h0, res_valid}, 32'h1);
    check("bp_busy", {31'h0, busy}, 32'h1);
    drain();
    check("bp_drained", got.size(), 8);

    // Output FIFO full, then simultaneous push/pop at one per cycle.
    fill_stalled();
    res_ready = 1'b1;
    in_valid  = 1'b1;
    pop0      = n_pop;
    acc_late  = 0;
    for (int i = 0; i < 16; i++) begin
      in_a = 8'(n_acc * 37 + 90);
      in_b = 8'(n_acc * 11 + 200);
      acc0 = n_acc;
      tick();
      if (i >= 8) acc_late += n_acc - acc0;
    end
    check("sim_pops", n_pop - pop0, 16);
    check("sim_steady_acc", acc_late, 8);
    drain();
    check("sim_sb_empty", sb.size(), 0);
    check("sim_busy", {31'h0, busy}, 32'h0);

    // Reset with work in flight/buffered; nothing stale may emerge.
    res_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = 8'h11; in_b = 8'h22; tick();
    in_a = 8'h33; in_b = 8'h44; tick();
    in_a = 8'h55; in_b = 8'h66; tick();
    in_valid = 1'b0;
    tick();
    check("mid_busy_before", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    tick();
    check("mid_res_valid", {31'h0, res_valid}, 32'h0);
    check("mid_busy", {31'h0, busy}, 32'h0);
    check("mid_in_ready", {31'h0, in_ready}, 32'h0);
    rst = 1'b1;
    res_ready = 1'b1;
    pop0 = n_pop;
    for (int i = 0; i < 6; i++) tick();
    check("mid_no_stale", n_pop - pop0, 0);
    got.delete();
    in_a = 8'h05; in_b = 8'h03; in_valid = 1'b1;
    tick();
    drain();
    check("mid_new_count", got.size(), 1);
    check("mid_new_data", {24'h0, got[0]}, 32'h08);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
